// File: rtl/mips_pipe_ctrl.sv
// mips_pipe_ctrl: pipelined control for the 5-stage MIPS core.
// Decodes the ID opcode into EX/MEM/WB bundles, carries them through
// ID/EX, EX/MEM and MEM/WB, and raises load-use stalls, jump and
// branch flushes.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   opcode_id         opcode of the IF/ID instruction
//   rs_id, rt_id      register fields of the IF/ID instruction
//   branch_taken_ex   branch resolved taken in EX
//   ex_ctrl           {RegDst, ALUOp[1:0], ALUSrc} from ID/EX
//   mem_ctrl          {Branch, MemRead, MemWrite} from EX/MEM
//   wb_ctrl           {RegWrite, MemtoReg} from MEM/WB
//   mem_regwrite      RegWrite held in EX/MEM (forwarding)
//   pc_write          PC update enable
//   ifid_write        IF/ID update enable
//   if_flush          IF/ID cleared to NOP at the next edge
//   jump              select jump target for PC
//   illegal_op        ID opcode not decodable
//
// Build option PERF_CNT_EN adds saturating stall_cnt / flush_cnt
// outputs (width CNT_W).

module mips_pipe_ctrl #(
  parameter int OPC_W = 6,
  parameter int REG_W = 5
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode_id,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             branch_taken_ex,
  output logic [3:0]       ex_ctrl,
  output logic [2:0]       mem_ctrl,
  output logic [1:0]       wb_ctrl,
  output logic             mem_regwrite,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             if_flush,
  output logic             jump,
  output logic             illegal_op
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b000010);

  // ID-stage decode
  logic [3:0] w_ex;
  logic [2:0] w_mem;
  logic [1:0] w_wb;
  logic       w_illegal;
  logic       w_is_j;
  logic       w_uses_rt;

  // pipeline control registers
  logic [3:0]       r_idex_ex;
  logic [2:0]       r_idex_mem;
  logic [1:0]       r_idex_wb;
  logic [REG_W-1:0] r_idex_rt;
  logic [2:0]       r_exmem_mem;
  logic [1:0]       r_exmem_wb;
  logic [1:0]       r_memwb_wb;

  // hazard / flush
  logic w_idex_memread;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_hazard;
  logic w_stall;
  logic w_kill;

  always_comb begin
    w_ex      = 4'b0000;
    w_mem     = 3'b000;
    w_wb      = 2'b00;
    w_illegal = 1'b0;
    w_is_j    = 1'b0;
    w_uses_rt = 1'b0;
    case (opcode_id)
      OP_R: begin
        w_ex      = 4'b1100;
        w_wb      = 2'b10;
        w_uses_rt = 1'b1;
      end
      OP_LW: begin
        w_ex  = 4'b0001;
        w_mem = 3'b010;
        w_wb  = 2'b11;
      end
      OP_SW: begin
        w_ex      = 4'b0001;
        w_mem     = 3'b001;
        w_uses_rt = 1'b1;
      end
      OP_BEQ: begin
        w_ex      = 4'b0010;
        w_mem     = 3'b100;
        w_uses_rt = 1'b1;
      end
      OP_ADDI: begin
        w_ex = 4'b0001;
        w_wb = 2'b10;
      end
      OP_J: begin
        w_is_j = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_idex_memread = r_idex_mem[1];
  assign w_rs_hit = (r_idex_rt == rs_id);
  assign w_rt_hit = w_uses_rt & (r_idex_rt == rt_id);

  assign w_hazard = w_idex_memread
                  & (r_idex_rt != '0)
                  & (w_rs_hit | w_rt_hit);

  // a taken branch kills the dependent instruction, so no stall
  assign w_stall = w_hazard & ~branch_taken_ex;

  // ID/EX takes a bubble on a stall or a branch flush
  assign w_kill = branch_taken_ex | w_hazard;

  assign pc_write   = rst_n & ~w_stall;
  assign ifid_write = rst_n & ~w_stall;

  assign jump = rst_n & w_is_j
              & ~branch_taken_ex & ~w_stall;

  assign if_flush = rst_n
                  & (branch_taken_ex | (w_is_j & ~w_stall));

  assign illegal_op = w_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idex_ex   <= '0;
      r_idex_mem  <= '0;
      r_idex_wb   <= '0;
      r_idex_rt   <= '0;
      r_exmem_mem <= '0;
      r_exmem_wb  <= '0;
      r_memwb_wb  <= '0;
    end else begin
      if (w_kill) begin
        r_idex_ex  <= '0;
        r_idex_mem <= '0;
        r_idex_wb  <= '0;
        r_idex_rt  <= '0;
      end else begin
        r_idex_ex  <= w_ex;
        r_idex_mem <= w_mem;
        r_idex_wb  <= w_wb;
        r_idex_rt  <= rt_id;
      end
      r_exmem_mem <= r_idex_mem;
      r_exmem_wb  <= r_idex_wb;
      r_memwb_wb  <= r_exmem_wb;
    end
  end

  assign ex_ctrl      = r_idex_ex;
  assign mem_ctrl     = r_exmem_mem;
  assign wb_ctrl      = r_memwb_wb;
  assign mem_regwrite = r_exmem_wb[1];

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (if_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// tb_mips_pipe_ctrl: scoreboard bench for mips_pipe_ctrl.
// Directed test-plan cases followed by randomized instruction streams.

module tb_mips_pipe_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode_id;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       branch_taken_ex;
  logic [3:0] ex_ctrl;
  logic [2:0] mem_ctrl;
  logic [1:0] wb_ctrl;
  logic       mem_regwrite;
  logic       pc_write;
  logic       ifid_write;
  logic       if_flush;
  logic       jump;
  logic       illegal_op;
`ifdef PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  mips_pipe_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .opcode_id       (opcode_id),
    .rs_id           (rs_id),
    .rt_id           (rt_id),
    .branch_taken_ex (branch_taken_ex),
    .ex_ctrl         (ex_ctrl),
    .mem_ctrl        (mem_ctrl),
    .wb_ctrl         (wb_ctrl),
    .mem_regwrite    (mem_regwrite),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .if_flush        (if_flush),
    .jump            (jump),
    .illegal_op      (illegal_op)
`ifdef PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one decoded instruction as the spec table describes it
  typedef struct packed {
    logic [3:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    logic [4:0] rt;
    logic       ld;
    logic       ur;
    logic       j;
    logic       ill;
  } slot_t;

  typedef struct packed {
    logic [3:0]  ex;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic        mrw;
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        jp;
    logic        ill;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t  sb[$];
  slot_t pipe[3];
  int    m_sc;
  int    m_fc;
  logic  last_hold;
  int    n_cmp;
  int    n_bad;

  function automatic slot_t dec(input logic [5:0] op,
                                input logic [4:0] rt);
    slot_t d;
    d = '0;
    d.rt = rt;
    case (op)
      6'b000000: begin
        d.ex = 4'b1100; d.wb = 2'b10; d.ur = 1'b1;
      end
      6'b100011: begin
        d.ex = 4'b0001; d.mem = 3'b010;
        d.wb = 2'b11; d.ld = 1'b1;
      end
      6'b101011: begin
        d.ex = 4'b0001; d.mem = 3'b001; d.ur = 1'b1;
      end
      6'b000100: begin
        d.ex = 4'b0010; d.mem = 3'b100; d.ur = 1'b1;
      end
      6'b001000: begin
        d.ex = 4'b0001; d.wb = 2'b10;
      end
      6'b000010: d.j = 1'b1;
      default:   d.ill = 1'b1;
    endcase
    return d;
  endfunction

  // one clock cycle: drive ID inputs, predict, advance model
  task automatic step(input logic [5:0] op,
                      input logic [4:0] rs,
                      input logic [4:0] rt,
                      input logic br,
                      input logic rn);
    slot_t d;
    slot_t nw;
    exp_t  e;
    logic  hz;
    @(posedge clk);
    #1;
    opcode_id = op;
    rs_id = rs;
    rt_id = rt;
    branch_taken_ex = br;
    rst_n = rn;
    d = dec(op, rt);
    hz = pipe[0].ld && pipe[0].rt != 0 &&
         (pipe[0].rt == rs ||
          (d.ur && pipe[0].rt == rt));
    e = '0;
    e.ex  = pipe[0].ex;
    e.mem = pipe[1].mem;
    e.wb  = pipe[2].wb;
    e.mrw = pipe[1].wb[1];
    e.ill = d.ill;
    e.sc  = 16'(m_sc);
    e.fc  = 16'(m_fc);
    if (!rn) begin
      e.pcw = 0; e.ifw = 0; e.fl = 0; e.jp = 0;
    end else if (br) begin
      e.pcw = 1; e.ifw = 1; e.fl = 1; e.jp = 0;
    end else if (hz) begin
      e.pcw = 0; e.ifw = 0; e.fl = 0; e.jp = 0;
    end else if (d.j) begin
      e.pcw = 1; e.ifw = 1; e.fl = 1; e.jp = 1;
    end else begin
      e.pcw = 1; e.ifw = 1; e.fl = 0; e.jp = 0;
    end
    sb.push_back(e);
    last_hold = rn && !e.ifw;
    if (!rn) begin
      pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
      m_sc = 0; m_fc = 0;
    end else begin
      nw = (br || hz) ? slot_t'(0) : d;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nw;
      if (hz && !br && m_sc < 65535) m_sc++;
      if (e.fl && m_fc < 65535) m_fc++;
    end
  endtask

  task automatic chk(input string nm, input int a, input int x);
    n_cmp++;
    if (a != x) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, a, x, $time);
    end
  endtask

  // monitor: outputs are stable mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ex_ctrl", int'(ex_ctrl), int'(e.ex));
      chk("mem_ctrl", int'(mem_ctrl), int'(e.mem));
      chk("wb_ctrl", int'(wb_ctrl), int'(e.wb));
      chk("mem_regwrite", int'(mem_regwrite), int'(e.mrw));
      chk("pc_write", int'(pc_write), int'(e.pcw));
      chk("ifid_write", int'(ifid_write), int'(e.ifw));
      chk("if_flush", int'(if_flush), int'(e.fl));
      chk("jump", int'(jump), int'(e.jp));
      chk("illegal_op", int'(illegal_op), int'(e.ill));
`ifdef PERF_CNT_EN
      chk("stall_cnt", int'(stall_cnt), int'(e.sc));
      chk("flush_cnt", int'(flush_cnt), int'(e.fc));
`endif
    end
  end

  localparam logic [5:0] R  = 6'b000000;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100;
  localparam logic [5:0] AI = 6'b001000;
  localparam logic [5:0] JJ = 6'b000010;
  localparam logic [5:0] IL = 6'b111111;

  initial begin
    logic [5:0] ops[8];
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       rn;
    n_cmp = 0;
    n_bad = 0;
    m_sc = 0;
    m_fc = 0;
    last_hold = 1'b0;
    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
    rst_n = 1'b0;
    opcode_id = LW;
    rs_id = '0;
    rt_id = '0;
    branch_taken_ex = 1'b0;
    ops[0] = R;  ops[1] = LW; ops[2] = SW; ops[3] = BQ;
    ops[4] = AI; ops[5] = JJ; ops[6] = IL; ops[7] = LW;

    // reset with lw in ID, then R-type through the pipe
    step(LW, 5'd1, 5'd2, 1'b0, 1'b0);
    step(LW, 5'd1, 5'd2, 1'b0, 1'b0);
    step(R, 5'd1, 5'd2, 1'b0, 1'b1);
    step(AI, 5'd0, 5'd9, 1'b0, 1'b1);
    step(AI, 5'd0, 5'd9, 1'b0, 1'b1);
    step(AI, 5'd0, 5'd9, 1'b0, 1'b1);
    // load-use on rs: one bubble
    step(LW, 5'd0, 5'd5, 1'b0, 1'b1);
    step(R, 5'd5, 5'd1, 1'b0, 1'b1);
    step(R, 5'd5, 5'd1, 1'b0, 1'b1);
    // lw rt=0 never stalls
    step(LW, 5'd0, 5'd0, 1'b0, 1'b1);
    step(AI, 5'd0, 5'd0, 1'b0, 1'b1);
    // sw uses rt, addi does not
    step(LW, 5'd0, 5'd7, 1'b0, 1'b1);
    step(SW, 5'd3, 5'd7, 1'b0, 1'b1);
    step(SW, 5'd3, 5'd7, 1'b0, 1'b1);
    step(LW, 5'd0, 5'd7, 1'b0, 1'b1);
    step(AI, 5'd3, 5'd7, 1'b0, 1'b1);
    // jump
    step(JJ, 5'd0, 5'd0, 1'b0, 1'b1);
    step(R, 5'd1, 5'd2, 1'b0, 1'b1);
    // branch + load-use + jump together, then stall + jump
    step(LW, 5'd0, 5'd4, 1'b0, 1'b1);
    step(JJ, 5'd4, 5'd4, 1'b1, 1'b1);
    step(LW, 5'd0, 5'd4, 1'b0, 1'b1);
    step(JJ, 5'd4, 5'd4, 1'b0, 1'b1);
    step(JJ, 5'd4, 5'd4, 1'b0, 1'b1);
    // illegal through the pipe
    step(IL, 5'd1, 5'd1, 1'b0, 1'b1);
    step(IL, 5'd1, 5'd1, 1'b0, 1'b1);
    step(IL, 5'd1, 5'd1, 1'b0, 1'b1);
    step(IL, 5'd1, 5'd1, 1'b0, 1'b1);

    // randomized stream; IF/ID holds its instruction on a stall
    op = R; rs = 0; rt = 0;
    for (int i = 0; i < 600; i++) begin
      if (!last_hold) begin
        if ($urandom_range(0, 9) == 0)
          op = 6'($urandom);
        else
          op = ops[$urandom_range(0, 7)];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
      end
      br = ($urandom_range(0, 7) == 0);
      rn = ($urandom_range(0, 79) != 0);
      step(op, rs, rt, br, rn);
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d expected 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_pipe_ctrl.md
Name: mips_pipe_ctrl

Overview:
Pipelined control unit for the 5-stage MIPS core. It decodes the ID-stage opcode into EX/MEM/WB control bundles and carries them through internal ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards and handles jump/branch flushes, so the datapath receives stage-aligned control, stall and flush signals from one block.

Parameters:
OPC_W, 6, opcode width
REG_W, 5, register-specifier width
CNT_W, 16, width of the performance counters (used only with PERF_CNT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
opcode_id  in  OPC_W  opcode of the instruction in IF/ID
rs_id  in  REG_W  rs field of the IF/ID instruction
rt_id  in  REG_W  rt field of the IF/ID instruction
branch_taken_ex  in  1  branch resolved taken in EX (Branch & Zero, from datapath)
ex_ctrl  out  4  ID/EX bundle {RegDst, ALUOp[1:0], ALUSrc}
mem_ctrl  out  3  EX/MEM bundle {Branch, MemRead, MemWrite}
wb_ctrl  out  2  MEM/WB bundle {RegWrite, MemtoReg}
mem_regwrite  out  1  RegWrite held in EX/MEM (for forwarding)
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID update enable
if_flush  out  1  IF/ID is cleared to NOP at the next edge
jump  out  1  select jump target for PC
illegal_op  out  1  ID opcode not decodable (combinational)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. While rst_n is 0 at a rising edge, all control registers clear to 0, including the internal idex_rt and idex_memread.
- Outputs while in reset: pc_write=0, ifid_write=0, if_flush=0, jump=0.
- Decode table (combinational, ID stage), given as EX/MEM/WB:
  - R-type 000000: 1100 / 000 / 10
  - lw 100011: 0001 / 010 / 11
  - sw 101011: 0001 / 001 / 00
  - beq 000100: 0010 / 100 / 00
  - addi 001000: 0001 / 000 / 10
  - j 000010: all bundles 0, jump candidate
  - Any other opcode: all bundles 0 and illegal_op=1.
  - No x values on any output.
- Pipeline advance: each rising edge moves the bundles ID->ID/EX->EX/MEM->MEM/WB. The WB portion travels through all three registers; the MEM portion through two; the EX portion through one. Control latency from decode to ex_ctrl is 1 cycle, to mem_ctrl 2 cycles, to wb_ctrl 3 cycles.
- Hazard (load-use) condition: stall = idex_memread & (idex_rt != 0) & ((idex_rt == rs_id) | (uses_rt & idex_rt == rt_id)).
  - uses_rt is 1 for R-type, sw and beq.
- Stall effect: pc_write=0 and ifid_write=0; zeros are written into ID/EX (bubble). EX/MEM and MEM/WB advance normally. A stall lasts exactly 1 cycle for a single load.
- Jump: when opcode_id=j and there is no stall and no branch_taken_ex, then jump=1 and if_flush=1.
- Branch taken: when branch_taken_ex=1, if_flush=1 and ID/EX is loaded with zeros. This kills the instructions in IF/ID and ID.
- Priority, highest first: reset > branch_taken_ex > stall > jump.
  - A branch together with a load-use hazard gives no stall: pc_write=1 and the flush proceeds.
  - A branch together with a jump gives jump=0.
  - A stall together with a jump holds: jump is deferred until the stall clears.
- Default (no event): pc_write=1, ifid_write=1, if_flush=0, jump=0.
- Bubbles and flushed slots carry RegWrite=0 and MemWrite=0, so they have no architectural effect.

Optional Feature:
PERF_CNT_EN
- Defined: adds output ports stall_cnt [CNT_W-1:0] and flush_cnt [CNT_W-1:0].
  - stall_cnt increments on every cycle with stall=1 that is not overridden by a branch.
  - flush_cnt increments on every cycle with if_flush=1.
  - Both counters saturate at all-ones and are cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with opcode_id=lw -> all bundles 0, pc_write=0. After release with R-type in ID -> ex_ctrl=1100 one cycle later, wb_ctrl=10 three cycles later.
- Load-use: lw rt=5 followed by an R-type with rs=5 -> exactly one cycle of pc_write=0 and ifid_write=0, ex_ctrl=0000 in the bubble cycle. The next cycle has ex_ctrl=1100. Repeat with addi rs=0 and lw rt=0 -> no stall.
- sw after lw using rt: lw rt=7, then sw rt_id=7 -> stall asserted. addi with rt_id=7 and rs=3 -> no stall.
- Jump: opcode_id=000010 -> jump=1, if_flush=1 in the same cycle, and ID/EX bundles 0 next cycle.
- Branch taken while a load-use hazard and a jump are present -> if_flush=1, jump=0, pc_write=1. Next ex_ctrl=0000.
- Illegal opcode 111111 -> illegal_op=1, all bundles 0 through the pipe. With PERF_CNT_EN: after 3 stalls and 2 flushes, stall_cnt=3 and flush_cnt=2.
